// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - player controls in, game state and enemy slots out
interface game_sequencer_if;
  logic        i_start;
  logic [2:0]  i_look;
  logic        i_shoot;
  logic        i_frame_tick;
  logic [1:0]  o_state;
  logic [3:0]  o_health;
  logic [7:0]  o_score;
  logic [5:0]  o_cooldown;
  logic [2:0]  o_enemy_active;
  logic [17:0] o_enemy_dist;
  logic [8:0]  o_enemy_dir;
  logic        o_fire_pulse;
  logic        o_hit_pulse;
  logic        o_game_end;

  modport master (
    output i_start, i_look, i_shoot, i_frame_tick,
    input  o_state, o_health, o_score, o_cooldown, o_enemy_active,
           o_enemy_dist, o_enemy_dir, o_fire_pulse, o_hit_pulse, o_game_end
  );

  modport slave (
    input  i_start, i_look, i_shoot, i_frame_tick,
    output o_state, o_health, o_score, o_cooldown, o_enemy_active,
           o_enemy_dist, o_enemy_dir, o_fire_pulse, o_hit_pulse, o_game_end
  );
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - HOME/PLAY/END game flow, enemies, weapon and scoring
module game_sequencer #(
  parameter logic [3:0] START_HEALTH    = 4'd3,
  parameter logic [5:0] COOLDOWN_FRAMES = 6'd30,
  parameter logic [7:0] SPAWN_PERIOD    = 8'd90,
  parameter logic [7:0] STEP_FRAMES     = 8'd4,
  parameter logic [5:0] MAX_DIST        = 6'd63,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input logic              clk,
  input logic              rst,
  game_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_HOME = 2'd0, S_PLAY = 2'd1, S_END = 2'd2} state_t;

  state_t          r_state, w_state_nx;
  logic [3:0]      r_health, w_health_nx;
  logic [7:0]      r_score, w_score_nx;
  logic [5:0]      r_cooldown, w_cooldown_nx;
  logic [2:0]      r_active, w_active_nx;
  logic [2:0][5:0] r_dist, w_dist_nx;
  logic [2:0][2:0] r_dir, w_dir_nx;
  logic [7:0]      r_spawn_cnt, w_spawn_cnt_nx;
  logic [7:0]      r_step_cnt, w_step_cnt_nx;
  logic [7:0]      r_lfsr, w_lfsr_nx;
  logic            r_fire, w_fire_nx;
  logic            r_hit, w_hit_nx;
  logic            r_game_end;
  logic            r_start_q, r_shoot_q;

  logic            w_start_rise, w_shoot_rise;
  logic            w_tgt_found;
  logic [1:0]      w_tgt;
  logic [5:0]      w_best;
  logic [2:0]      w_kill;
  logic            w_do_step, w_do_spawn, w_spawn_done;

  assign w_start_rise = bus.i_start & ~r_start_q;
  assign w_shoot_rise = bus.i_shoot & ~r_shoot_q;

  // State register and all gameplay registers; game_end tracks the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_HOME;
      r_health    <= START_HEALTH;
      r_score     <= 8'd0;
      r_cooldown  <= 6'd0;
      r_active    <= 3'd0;
      r_dist      <= '0;
      r_dir       <= '0;
      r_spawn_cnt <= 8'd0;
      r_step_cnt  <= 8'd0;
      r_lfsr      <= LFSR_SEED;
      r_fire      <= 1'b0;
      r_hit       <= 1'b0;
      r_game_end  <= 1'b0;
      r_start_q   <= 1'b0;
      r_shoot_q   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_health    <= w_health_nx;
      r_score     <= w_score_nx;
      r_cooldown  <= w_cooldown_nx;
      r_active    <= w_active_nx;
      r_dist      <= w_dist_nx;
      r_dir       <= w_dir_nx;
      r_spawn_cnt <= w_spawn_cnt_nx;
      r_step_cnt  <= w_step_cnt_nx;
      r_lfsr      <= w_lfsr_nx;
      r_fire      <= w_fire_nx;
      r_hit       <= w_hit_nx;
      r_game_end  <= (w_state_nx == S_END);
      r_start_q   <= bus.i_start;
      r_shoot_q   <= bus.i_shoot;
    end
  end

  // Next state and per-frame game update: shot, cooldown, step, spawn, LFSR
  always_comb begin
    w_state_nx     = r_state;
    w_health_nx    = r_health;
    w_score_nx     = r_score;
    w_cooldown_nx  = r_cooldown;
    w_active_nx    = r_active;
    w_dist_nx      = r_dist;
    w_dir_nx       = r_dir;
    w_spawn_cnt_nx = r_spawn_cnt;
    w_step_cnt_nx  = r_step_cnt;
    w_lfsr_nx      = r_lfsr;
    w_fire_nx      = 1'b0;
    w_hit_nx       = 1'b0;
    w_tgt_found    = 1'b0;
    w_tgt          = 2'd0;
    w_best         = 6'd0;
    w_kill         = 3'd0;
    w_do_step      = 1'b0;
    w_do_spawn     = 1'b0;
    w_spawn_done   = 1'b0;

    case (r_state)
      S_HOME: begin
        if (w_start_rise) begin
          w_state_nx     = S_PLAY;
          w_health_nx    = START_HEALTH;
          w_score_nx     = 8'd0;
          w_cooldown_nx  = 6'd0;
          w_active_nx    = 3'd0;
          w_dist_nx      = '0;
          w_dir_nx       = '0;
          w_spawn_cnt_nx = 8'd0;
          w_step_cnt_nx  = 8'd0;
          w_lfsr_nx      = LFSR_SEED;
        end
      end

      S_PLAY: begin
        // nearest enemy in the look direction; strict < keeps the lowest index on ties
        for (int i = 0; i < 3; i++) begin
          if (r_active[i] && (r_dir[i] == bus.i_look) &&
              (!w_tgt_found || (r_dist[i] < w_best))) begin
            w_tgt_found = 1'b1;
            w_tgt       = 2'(i);
            w_best      = r_dist[i];
          end
        end

        if (w_shoot_rise && (r_cooldown == 6'd0)) begin
          w_fire_nx     = 1'b1;
          w_cooldown_nx = COOLDOWN_FRAMES;
          if (w_tgt_found) begin
            w_kill[w_tgt] = 1'b1;
            w_hit_nx      = 1'b1;
            w_score_nx    = (r_score != 8'hFF) ? r_score + 8'd1 : r_score;
          end
        end else if (bus.i_frame_tick && (r_cooldown != 6'd0)) begin
          w_cooldown_nx = r_cooldown - 6'd1;
        end

        if (bus.i_frame_tick) begin
          w_step_cnt_nx = r_step_cnt + 8'd1;
          if (w_step_cnt_nx == STEP_FRAMES) begin
            w_step_cnt_nx = 8'd0;
            w_do_step     = 1'b1;
          end
          w_spawn_cnt_nx = r_spawn_cnt + 8'd1;
          if (w_spawn_cnt_nx == SPAWN_PERIOD) begin
            w_spawn_cnt_nx = 8'd0;
            w_do_spawn     = 1'b1;
          end
          w_lfsr_nx = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end

        // a killed slot is cleared before it can reach, so no damage from it
        for (int i = 0; i < 3; i++) begin
          if (w_kill[i]) begin
            w_active_nx[i] = 1'b0;
            w_dist_nx[i]   = 6'd0;
            w_dir_nx[i]    = 3'd0;
          end else if (w_do_step && r_active[i]) begin
            if (r_dist[i] != 6'd0) begin
              w_dist_nx[i] = r_dist[i] - 6'd1;
            end else begin
              w_active_nx[i] = 1'b0;
              w_dir_nx[i]    = 3'd0;
              if (w_health_nx != 4'd0) w_health_nx = w_health_nx - 4'd1;
            end
          end
        end

        // only slots empty at the start of this clk take the new enemy
        if (w_do_spawn) begin
          for (int i = 0; i < 3; i++) begin
            if (!r_active[i] && !w_spawn_done) begin
              w_spawn_done   = 1'b1;
              w_active_nx[i] = 1'b1;
              w_dist_nx[i]   = MAX_DIST;
              w_dir_nx[i]    = r_lfsr[2:0];
            end
          end
        end

        if (w_health_nx == 4'd0) w_state_nx = S_END;
      end

      S_END: begin
        if (w_start_rise) w_state_nx = S_HOME;
      end

      default: w_state_nx = S_HOME;
    endcase
  end

  assign bus.o_state        = r_state;
  assign bus.o_health       = r_health;
  assign bus.o_score        = r_score;
  assign bus.o_cooldown     = r_cooldown;
  assign bus.o_enemy_active = r_active;
  assign bus.o_enemy_dist   = r_dist;
  assign bus.o_enemy_dir    = r_dir;
  assign bus.o_fire_pulse   = r_fire;
  assign bus.o_hit_pulse    = r_hit;
  assign bus.o_game_end     = r_game_end;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed bench for game_sequencer
module tb_game_sequencer;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  game_sequencer_if if_a ();
  game_sequencer_if if_b ();

  game_sequencer #(
    .START_HEALTH(4'd3), .COOLDOWN_FRAMES(6'd2), .SPAWN_PERIOD(8'd3),
    .STEP_FRAMES(8'd1), .MAX_DIST(6'd4), .LFSR_SEED(8'hA5)
  ) u_dut_a (.clk(clk), .rst(rst_a), .bus(if_a));

  game_sequencer #(
    .START_HEALTH(4'd3), .COOLDOWN_FRAMES(6'd1), .SPAWN_PERIOD(8'd1),
    .STEP_FRAMES(8'd1), .MAX_DIST(6'd4), .LFSR_SEED(8'hA5)
  ) u_dut_b (.clk(clk), .rst(rst_b), .bus(if_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_a(input int n);
    for (int k = 0; k < n; k++) begin
      if_a.i_frame_tick = 1'b1;
      cyc();
      if_a.i_frame_tick = 1'b0;
    end
  endtask

  task automatic tick_b(input int n);
    for (int k = 0; k < n; k++) begin
      if_b.i_frame_tick = 1'b1;
      cyc();
      if_b.i_frame_tick = 1'b0;
    end
  endtask

  task automatic fire_b(input logic [2:0] dir);
    if_b.i_look  = dir;
    if_b.i_shoot = 1'b1;
    cyc();
    if_b.i_shoot = 1'b0;
  endtask

  initial begin
    if_a.i_start = 1'b0; if_a.i_look = 3'd0; if_a.i_shoot = 1'b0; if_a.i_frame_tick = 1'b0;
    if_b.i_start = 1'b0; if_b.i_look = 3'd0; if_b.i_shoot = 1'b0; if_b.i_frame_tick = 1'b0;
    cyc(); cyc();
    rst_a = 1'b1; rst_b = 1'b1;
    cyc();

    chk("rst_state",  32'(if_a.o_state), 0);
    chk("rst_health", 32'(if_a.o_health), 3);
    chk("rst_score",  32'(if_a.o_score), 0);
    chk("rst_cool",   32'(if_a.o_cooldown), 0);
    chk("rst_active", 32'(if_a.o_enemy_active), 0);
    chk("rst_dist",   32'(if_a.o_enemy_dist), 0);
    chk("rst_dir",    32'(if_a.o_enemy_dir), 0);
    chk("rst_end",    32'(if_a.o_game_end), 0);
    chk("rst_fire",   32'(if_a.o_fire_pulse), 0);

    // ---- DUT A game 1: spawns, steps, reaches, end ----
    if_a.i_start = 1'b1; cyc();
    chk("a_play",   32'(if_a.o_state), 1);
    chk("a_health", 32'(if_a.o_health), 3);
    chk("a_score",  32'(if_a.o_score), 0);
    if_a.i_start = 1'b0; cyc();

    tick_a(3);
    chk("a_t3_act",  32'(if_a.o_enemy_active), 3'b001);
    chk("a_t3_dist", 32'(if_a.o_enemy_dist), 32'({6'd0, 6'd0, 6'd4}));
    chk("a_t3_dir",  32'(if_a.o_enemy_dir), 32'({3'd0, 3'd0, 3'd5}));
    tick_a(1);
    chk("a_t4_dist", 32'(if_a.o_enemy_dist), 32'({6'd0, 6'd0, 6'd3}));
    tick_a(2);
    chk("a_t6_act",  32'(if_a.o_enemy_active), 3'b011);
    chk("a_t6_dist", 32'(if_a.o_enemy_dist), 32'({6'd0, 6'd4, 6'd1}));
    chk("a_t6_dir",  32'(if_a.o_enemy_dir), 32'({3'd0, 3'd1, 3'd5}));
    tick_a(1);
    chk("a_t7_dist", 32'(if_a.o_enemy_dist), 32'({6'd0, 6'd3, 6'd0}));
    chk("a_t7_hp",   32'(if_a.o_health), 3);
    tick_a(1);
    chk("a_t8_act",  32'(if_a.o_enemy_active), 3'b010);
    chk("a_t8_hp",   32'(if_a.o_health), 2);
    chk("a_t8_dist", 32'(if_a.o_enemy_dist), 32'({6'd0, 6'd2, 6'd0}));
    tick_a(1);
    chk("a_t9_act",  32'(if_a.o_enemy_active), 3'b011);
    chk("a_t9_dist", 32'(if_a.o_enemy_dist), 32'({6'd0, 6'd1, 6'd4}));
    chk("a_t9_dir",  32'(if_a.o_enemy_dir), 32'({3'd0, 3'd1, 3'd6}));
    tick_a(2);
    chk("a_t11_act", 32'(if_a.o_enemy_active), 3'b001);
    chk("a_t11_hp",  32'(if_a.o_health), 1);
    tick_a(2);
    chk("a_t13_state", 32'(if_a.o_state), 1);
    tick_a(1);
    chk("a_t14_hp",    32'(if_a.o_health), 0);
    chk("a_t14_state", 32'(if_a.o_state), 2);
    chk("a_t14_end",   32'(if_a.o_game_end), 1);
    chk("a_t14_act",   32'(if_a.o_enemy_active), 3'b010);
    chk("a_t14_dir",   32'(if_a.o_enemy_dir), 32'({3'd0, 3'd7, 3'd0}));

    if_a.i_look = 3'd7; if_a.i_shoot = 1'b1; if_a.i_frame_tick = 1'b1; cyc();
    if_a.i_frame_tick = 1'b0; if_a.i_shoot = 1'b0;
    chk("a_end_fire",  32'(if_a.o_fire_pulse), 0);
    chk("a_end_dist",  32'(if_a.o_enemy_dist), 32'({6'd0, 6'd2, 6'd0}));
    chk("a_end_score", 32'(if_a.o_score), 0);
    cyc();
    chk("a_end_hold",  32'(if_a.o_state), 2);
    if_a.i_start = 1'b1; cyc(); if_a.i_start = 1'b0;
    chk("a_home",      32'(if_a.o_state), 0);
    chk("a_home_end",  32'(if_a.o_game_end), 0);
    chk("a_home_hp",   32'(if_a.o_health), 0);
    cyc();

    // ---- DUT A game 2: kill, cooldown, empty shot, async reset ----
    if_a.i_start = 1'b1; cyc(); if_a.i_start = 1'b0;
    chk("a2_state", 32'(if_a.o_state), 1);
    chk("a2_hp",    32'(if_a.o_health), 3);
    chk("a2_act",   32'(if_a.o_enemy_active), 0);
    tick_a(3);
    if_a.i_look = 3'd5; if_a.i_shoot = 1'b1; cyc();
    chk("a2_fire",   32'(if_a.o_fire_pulse), 1);
    chk("a2_hit",    32'(if_a.o_hit_pulse), 1);
    chk("a2_score",  32'(if_a.o_score), 1);
    chk("a2_act0",   32'(if_a.o_enemy_active), 0);
    chk("a2_cool",   32'(if_a.o_cooldown), 2);
    cyc();
    chk("a2_fire_1clk", 32'(if_a.o_fire_pulse), 0);
    chk("a2_hit_1clk",  32'(if_a.o_hit_pulse), 0);
    if_a.i_shoot = 1'b0; cyc();
    if_a.i_shoot = 1'b1; cyc();
    chk("a2_cd_block", 32'(if_a.o_fire_pulse), 0);
    chk("a2_cd_hold",  32'(if_a.o_cooldown), 2);
    if_a.i_shoot = 1'b0;
    tick_a(1);
    chk("a2_cd1", 32'(if_a.o_cooldown), 1);
    tick_a(1);
    chk("a2_cd0", 32'(if_a.o_cooldown), 0);
    if_a.i_look = 3'd3; if_a.i_shoot = 1'b1; cyc(); if_a.i_shoot = 1'b0;
    chk("a2_miss_fire",  32'(if_a.o_fire_pulse), 1);
    chk("a2_miss_hit",   32'(if_a.o_hit_pulse), 0);
    chk("a2_miss_score", 32'(if_a.o_score), 1);

    @(posedge clk); #3;
    rst_a = 1'b0; #1;
    chk("a_arst_state", 32'(if_a.o_state), 0);
    chk("a_arst_score", 32'(if_a.o_score), 0);
    chk("a_arst_cool",  32'(if_a.o_cooldown), 0);
    chk("a_arst_hp",    32'(if_a.o_health), 3);
    cyc(); rst_a = 1'b1;

    // ---- DUT B: spawn every tick, nearest-target choice, kill vs reach ----
    if_b.i_start = 1'b1; cyc(); if_b.i_start = 1'b0;
    chk("b_state", 32'(if_b.o_state), 1);
    tick_b(3);
    chk("b_t3_act",  32'(if_b.o_enemy_active), 3'b111);
    chk("b_t3_dist", 32'(if_b.o_enemy_dist), 32'({6'd4, 6'd3, 6'd2}));
    chk("b_t3_dir",  32'(if_b.o_enemy_dir), 32'({3'd5, 3'd2, 3'd5}));
    fire_b(3'd5);
    chk("b_k1_act",  32'(if_b.o_enemy_active), 3'b110);
    chk("b_k1_dir",  32'(if_b.o_enemy_dir), 32'({3'd5, 3'd2, 3'd0}));
    chk("b_k1_score", 32'(if_b.o_score), 1);
    cyc();
    tick_b(1);
    chk("b_t4_dist", 32'(if_b.o_enemy_dist), 32'({6'd3, 6'd2, 6'd4}));
    chk("b_t4_dir",  32'(if_b.o_enemy_dir), 32'({3'd5, 3'd2, 3'd2}));
    chk("b_t4_cool", 32'(if_b.o_cooldown), 0);
    fire_b(3'd2);
    chk("b_k2_act",  32'(if_b.o_enemy_active), 3'b101);
    chk("b_k2_dist", 32'(if_b.o_enemy_dist), 32'({6'd3, 6'd0, 6'd4}));
    chk("b_k2_hit",  32'(if_b.o_hit_pulse), 1);
    cyc();
    tick_b(1);
    chk("b_t5_dist", 32'(if_b.o_enemy_dist), 32'({6'd2, 6'd4, 6'd3}));
    chk("b_t5_dir",  32'(if_b.o_enemy_dir), 32'({3'd5, 3'd4, 3'd2}));
    tick_b(1);
    chk("b_t6_dist", 32'(if_b.o_enemy_dist), 32'({6'd1, 6'd3, 6'd2}));
    tick_b(1);
    chk("b_t7_dist", 32'(if_b.o_enemy_dist), 32'({6'd0, 6'd2, 6'd1}));
    if_b.i_look = 3'd5; if_b.i_shoot = 1'b1; if_b.i_frame_tick = 1'b1; cyc();
    if_b.i_frame_tick = 1'b0; if_b.i_shoot = 1'b0;
    chk("b_t8_score", 32'(if_b.o_score), 3);
    chk("b_t8_hp",    32'(if_b.o_health), 3);
    chk("b_t8_cool",  32'(if_b.o_cooldown), 1);
    chk("b_t8_act",   32'(if_b.o_enemy_active), 3'b011);
    chk("b_t8_dist",  32'(if_b.o_enemy_dist), 32'({6'd0, 6'd1, 6'd0}));
    chk("b_t8_dir",   32'(if_b.o_enemy_dir), 32'({3'd0, 3'd4, 3'd2}));
    tick_b(1);
    chk("b_t9_hp",   32'(if_b.o_health), 2);
    chk("b_t9_act",  32'(if_b.o_enemy_active), 3'b110);
    chk("b_t9_dist", 32'(if_b.o_enemy_dist), 32'({6'd4, 6'd0, 6'd0}));
    chk("b_t9_dir",  32'(if_b.o_enemy_dir), 32'({3'd6, 3'd4, 3'd0}));
    chk("b_t9_cool", 32'(if_b.o_cooldown), 0);
    fire_b(3'd3);
    chk("b_miss_fire",  32'(if_b.o_fire_pulse), 1);
    chk("b_miss_hit",   32'(if_b.o_hit_pulse), 0);
    chk("b_miss_score", 32'(if_b.o_score), 3);
    chk("b_miss_act",   32'(if_b.o_enemy_active), 3'b110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
